// File: rtl/sel_pkg.sv
// Shared widths, defaults and debounce state encoding for the select/data front end.
package sel_pkg;
    localparam int SEL_W   = 2;
    localparam int DATA_W  = 4;
    localparam int NUM_BTN = 3;

    localparam int DB_CYCLES_DEF = 1_000_000;
    localparam int SCAN_DIV_DEF  = 50_000_000;

    // Bit positions of the buttons in the packed button vectors.
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_LOAD = 2;

    typedef enum logic [1:0] {
        LO_STABLE,
        LO_TO_HI,
        HI_STABLE,
        HI_TO_LO
    } db_state_t;
endpackage

// File: rtl/sel_scanner_if.sv
// Button/switch inputs and decoder-facing sel/data outputs of sel_scanner.
// scan_en exists only when SEL_AUTOSCAN_EN is defined.
interface sel_scanner_if;
    import sel_pkg::*;

    logic              btn_up;
    logic              btn_down;
    logic              btn_load;
    logic [DATA_W-1:0] sw;
`ifdef SEL_AUTOSCAN_EN
    logic              scan_en;
`endif
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;

    modport master (
        output btn_up, btn_down, btn_load, sw,
`ifdef SEL_AUTOSCAN_EN
        output scan_en,
`endif
        input  sel, data
    );

    modport slave (
        input  btn_up, btn_down, btn_load, sw,
`ifdef SEL_AUTOSCAN_EN
        input  scan_en,
`endif
        output sel, data
    );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, 4-state debounce FSM with stability counter,
// debounced level and a single-cycle press pulse on each accepted 0->1 change.
module btn_debounce
    import sel_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync;
    logic             s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    db_state_t        state, state_nxt;
    logic             level_d;

    assign s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            state   <= LO_STABLE;
            cnt     <= '0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_d <= level;
        end
    end

    // The flip happens on the edge where the count would reach DB_CYCLES, so
    // the stored count stays below DB_CYCLES.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LO_STABLE: if (s) begin
                state_nxt = LO_TO_HI;
                cnt_nxt   = CNT_W'(1);
            end
            LO_TO_HI: begin
                if (!s) begin
                    state_nxt = LO_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HI_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HI_STABLE: if (!s) begin
                state_nxt = HI_TO_LO;
                cnt_nxt   = CNT_W'(1);
            end
            HI_TO_LO: begin
                if (s) begin
                    state_nxt = HI_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LO_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = LO_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign level = (state == HI_STABLE) || (state == HI_TO_LO);
    assign press = level & ~level_d;
endmodule

// File: rtl/sel_scanner.sv
// Debounced up/down/load front end feeding the LED decoder with registered sel/data.
// Optional feature macro: SEL_AUTOSCAN_EN (adds scan_en and the auto-scan prescaler).
module sel_scanner
    import sel_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int SCAN_DIV  = SCAN_DIV_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sel_scanner_if.slave  bus
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] lvl_unused;  // only press edges drive state here
    logic [DATA_W-1:0]  sw_m, sw_s;
    logic [SEL_W-1:0]   sel_q, sel_nxt;
    logic [DATA_W-1:0]  data_q;

    assign btn_raw = {bus.btn_load, bus.btn_down, bus.btn_up};

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_raw),
        .level (lvl_unused),
        .press (press)
    );

`ifdef SEL_AUTOSCAN_EN
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    logic [PRE_W-1:0] pre_cnt;
    logic             scan_wrap;

    assign scan_wrap = bus.scan_en && (pre_cnt == PRE_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         pre_cnt <= '0;
        else if (!bus.scan_en || scan_wrap) pre_cnt <= '0;
        else                             pre_cnt <= pre_cnt + 1'b1;
    end
`endif

    always_comb begin
        sel_nxt = sel_q;
`ifdef SEL_AUTOSCAN_EN
        if (bus.scan_en) begin
            if (scan_wrap) sel_nxt = sel_q + 1'b1;
        end else
`endif
        case ({press[BTN_DOWN], press[BTN_UP]})
            2'b01:   sel_nxt = sel_q + 1'b1;
            2'b10:   sel_nxt = sel_q - 1'b1;
            default: sel_nxt = sel_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m   <= '0;
            sw_s   <= '0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            sw_m  <= bus.sw;
            sw_s  <= sw_m;
            sel_q <= sel_nxt;
            if (press[BTN_LOAD]) data_q <= sw_s;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.data = data_q;
endmodule
